// File: rtl/lane_deskew_ctrl_pkg.sv
// Shared constants and FSM state encoding for the lane deskew controller.
package lane_deskew_ctrl_pkg;

    localparam int N_LANES        = 20;
    localparam int FIFO_DEPTH     = 20;
    localparam int MAX_SKEW       = 16;
    localparam int NB_DELAY_COUNT = $clog2(FIFO_DEPTH);

    // Counter-width copies so comparisons and increments stay width-matched
    localparam logic [NB_DELAY_COUNT-1:0] MAX_SKEW_CNT = NB_DELAY_COUNT'(MAX_SKEW);
    localparam logic [NB_DELAY_COUNT-1:0] CNT_ZERO     = NB_DELAY_COUNT'(0);
    localparam logic [NB_DELAY_COUNT-1:0] CNT_ONE      = NB_DELAY_COUNT'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FIRST = 3'd1,
        ST_COUNT      = 3'd2,
        ST_SET        = 3'd3,
        ST_DESKEWED   = 3'd4,
        ST_INVALID    = 3'd5
    } state_t;

endpackage

// File: rtl/lane_deskew_ctrl_stamp.sv
// Per-lane alignment-marker timestamp: remembers whether the lane's AM has
// been seen in the current round and the counter value at first arrival.
module deskew_lane_stamp
    import lane_deskew_ctrl_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      capture,
    input  logic [NB_DELAY_COUNT-1:0] counter,
    output logic                      seen,
    output logic [NB_DELAY_COUNT-1:0] arrival
);

    // Capture the first arrival only; repeated tags within a round are ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            seen    <= 1'b0;
            arrival <= CNT_ZERO;
        end else if (enable) begin
            if (clear) begin
                seen    <= 1'b0;
                arrival <= CNT_ZERO;
            end else if (capture && !seen) begin
                seen    <= 1'b1;
                arrival <= counter;
            end
        end
    end

endmodule

// File: rtl/lane_deskew_ctrl.sv
// Lane deskew controller: timestamps per-lane AM arrival within one round,
// derives per-lane FIFO delays, loads them and then enables aligned read-out.
module lane_deskew_ctrl
    import lane_deskew_ctrl_pkg::*;
(
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_valid,
    input  logic                                i_all_lanes_locked,
    input  logic [N_LANES-1:0]                  i_am_tag,
    output logic                                o_write_enb,
    output logic [N_LANES-1:0]                  o_read_enb,
    output logic [N_LANES-1:0]                  o_set_fifo_delay,
    output logic [N_LANES*NB_DELAY_COUNT-1:0]   o_lane_delay,
    output logic                                o_deskew_done,
    output logic                                o_invalid_skew
);

    state_t                                  state;
    state_t                                  state_nxt;
    logic [NB_DELAY_COUNT-1:0]               counter;
    logic [N_LANES-1:0]                      seen;
    logic [N_LANES-1:0][NB_DELAY_COUNT-1:0]  arrival;
    logic [N_LANES-1:0][NB_DELAY_COUNT-1:0]  arrival_nxt;
    logic [N_LANES-1:0]                      capture;
    logic                                    window;
    logic                                    all_seen_nxt;
    logic                                    clear;
    logic [NB_DELAY_COUNT-1:0]               last_arrival;
    logic [N_LANES*NB_DELAY_COUNT-1:0]       delay_nxt;

    // Tags count only while a round is open and the link is locked
    assign window       = ((state == ST_WAIT_FIRST) || (state == ST_COUNT)) && i_all_lanes_locked;
    assign capture      = i_am_tag & {N_LANES{window}};
    assign all_seen_nxt = &(seen | capture);
    assign clear        = (state_nxt == ST_IDLE) || (state == ST_INVALID);

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        deskew_lane_stamp u_stamp (
            .clock   (i_clock),
            .reset   (i_reset),
            .enable  (i_valid),
            .clear   (clear),
            .capture (capture[k]),
            .counter (counter),
            .seen    (seen[k]),
            .arrival (arrival[k])
        );
    end

    // Arrivals as they will be after this cycle, so SET can load delays including this cycle's tags
    always_comb begin
        arrival_nxt = '{default: CNT_ZERO};
        for (int k = 0; k < N_LANES; k++) begin
            if (seen[k]) begin
                arrival_nxt[k] = arrival[k];
            end else if (capture[k]) begin
                arrival_nxt[k] = counter;
            end else begin
                arrival_nxt[k] = CNT_ZERO;
            end
        end
    end

    // Latest arrival and per-lane delay; earliest lane waits longest
    always_comb begin
        last_arrival = CNT_ZERO;
        delay_nxt    = {(N_LANES*NB_DELAY_COUNT){1'b0}};
        for (int k = 0; k < N_LANES; k++) begin
            if (arrival_nxt[k] > last_arrival) begin
                last_arrival = arrival_nxt[k];
            end else begin
                last_arrival = last_arrival;
            end
        end
        for (int k = 0; k < N_LANES; k++) begin
            delay_nxt[k*NB_DELAY_COUNT +: NB_DELAY_COUNT] = last_arrival - arrival_nxt[k];
        end
    end

    // Next-state decision; loss of lock overrides every other transition
    always_comb begin
        state_nxt = state;
        if (!i_all_lanes_locked) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       state_nxt = ST_WAIT_FIRST;
                ST_WAIT_FIRST: begin
                    if (|i_am_tag) begin
                        state_nxt = all_seen_nxt ? ST_SET : ST_COUNT;
                    end else begin
                        state_nxt = ST_WAIT_FIRST;
                    end
                end
                ST_COUNT: begin
                    if (all_seen_nxt) begin
                        state_nxt = ST_SET;
                    end else if (counter == MAX_SKEW_CNT) begin
                        state_nxt = ST_INVALID;
                    end else begin
                        state_nxt = ST_COUNT;
                    end
                end
                ST_SET:        state_nxt = ST_DESKEWED;
                ST_DESKEWED:   state_nxt = ST_DESKEWED;
                ST_INVALID:    state_nxt = ST_WAIT_FIRST;
                default:       state_nxt = ST_IDLE;
            endcase
        end
    end

    // Round counter: starts at 1 after the first AM and saturates at MAX_SKEW
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            counter <= CNT_ZERO;
        end else if (i_valid) begin
            if (clear) begin
                counter <= CNT_ZERO;
            end else if ((state == ST_WAIT_FIRST) && (state_nxt == ST_COUNT)) begin
                counter <= CNT_ONE;
            end else if ((state == ST_COUNT) && (state_nxt == ST_COUNT)) begin
                counter <= counter + CNT_ONE;
            end
        end
    end

    // State register with outputs registered from the state being entered
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            o_write_enb      <= 1'b0;
            o_read_enb       <= {N_LANES{1'b0}};
            o_set_fifo_delay <= {N_LANES{1'b0}};
            o_lane_delay     <= {(N_LANES*NB_DELAY_COUNT){1'b0}};
            o_deskew_done    <= 1'b0;
            o_invalid_skew   <= 1'b0;
        end else if (i_valid) begin
            state            <= state_nxt;
            o_write_enb      <= (state_nxt != ST_IDLE);
            o_read_enb       <= {N_LANES{state_nxt == ST_DESKEWED}};
            o_set_fifo_delay <= {N_LANES{state_nxt == ST_SET}};
            o_deskew_done    <= (state_nxt == ST_DESKEWED);
            o_invalid_skew   <= (state_nxt == ST_INVALID);
            if (state_nxt == ST_IDLE) begin
                o_lane_delay <= {(N_LANES*NB_DELAY_COUNT){1'b0}};
            end else if (state_nxt == ST_SET) begin
                o_lane_delay <= delay_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Scoreboard bench for lane_deskew_ctrl: directed AM-tag sequences push
// expected SET / DONE / INVALID events; a negedge monitor pops and compares.
module tb_lane_deskew_ctrl;

    localparam int NL = 20;
    localparam int NB = 5;
    localparam int DW = NL * NB;

    localparam int EV_SET  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_INV  = 2;

    localparam logic [NL-1:0] ALL   = {NL{1'b1}};
    localparam logic [NL-1:0] NONE  = {NL{1'b0}};
    localparam logic [NL-1:0] L0    = 20'h00001;
    localparam logic [NL-1:0] L3    = 20'h00008;
    localparam logic [NL-1:0] L7    = 20'h00080;
    localparam logic [NL-1:0] L19   = 20'h80000;
    localparam logic [NL-1:0] MID   = 20'h7FFFE;
    localparam logic [NL-1:0] NOT0  = 20'hFFFFE;
    localparam logic [NL-1:0] NOT3  = 20'hFFFF7;
    localparam logic [NL-1:0] NOT7  = 20'hFFF7F;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid;
    logic          lock;
    logic [NL-1:0] tag;
    logic          o_write_enb;
    logic [NL-1:0] o_read_enb;
    logic [NL-1:0] o_set_fifo_delay;
    logic [DW-1:0] o_lane_delay;
    logic          o_deskew_done;
    logic          o_invalid_skew;

    typedef struct {
        int            kind;
        logic [DW-1:0] delay;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic fresh_r   = 1'b0;
    logic done_prev = 1'b0;

    always #5 clock = ~clock;

    lane_deskew_ctrl dut (
        .i_clock            (clock),
        .i_reset            (reset),
        .i_valid            (valid),
        .i_all_lanes_locked (lock),
        .i_am_tag           (tag),
        .o_write_enb        (o_write_enb),
        .o_read_enb         (o_read_enb),
        .o_set_fifo_delay   (o_set_fifo_delay),
        .o_lane_delay       (o_lane_delay),
        .o_deskew_done      (o_deskew_done),
        .o_invalid_skew     (o_invalid_skew)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {o_write_enb, o_read_enb, o_set_fifo_delay, o_deskew_done, o_invalid_skew, o_lane_delay},
              160'd0);
    endtask

    // Delay vector: lane la gets da, lane lb gets db, every other lane dother
    function automatic logic [DW-1:0] dvec(input int la, input int da, input int lb, input int db, input int dother);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < NL; k++) begin
            if (k == la) v[k*NB +: NB] = NB'(da);
            else if (k == lb) v[k*NB +: NB] = NB'(db);
            else v[k*NB +: NB] = NB'(dother);
        end
        return v;
    endfunction

    task automatic push_exp(input int kind, input logic [DW-1:0] d);
        exp_t e;
        e.kind  = kind;
        e.delay = d;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic l, input logic [NL-1:0] t);
        valid = v;
        lock  = l;
        tag   = t;
        @(posedge clock);
        #2;
    endtask

    task automatic expect_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got event kind %0d, expected no event", kind);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == EV_SET) begin
                check("set_strobe", o_set_fifo_delay, ALL);
                check("set_lane_delay", o_lane_delay, e.delay);
                check("set_write_enb", o_write_enb, 1'b1);
            end else if (e.kind == EV_DONE) begin
                check("done_read_enb", o_read_enb, ALL);
                check("done_lane_delay", o_lane_delay, e.delay);
                check("done_set_cleared", o_set_fifo_delay, NONE);
            end else begin
                check("inv_no_done", {o_deskew_done, o_set_fifo_delay}, 160'd0);
            end
        end
    endtask

    // Outputs refresh only on valid edges; remember whether the last edge was one
    always @(posedge clock) fresh_r <= valid;

    // Monitor: any freshly presented event is popped from the scoreboard and compared
    always @(negedge clock) begin
        if (fresh_r) begin
            if (o_set_fifo_delay != NONE) expect_event(EV_SET);
            if (o_invalid_skew) expect_event(EV_INV);
            if (o_deskew_done && !done_prev) expect_event(EV_DONE);
        end
        done_prev <= o_deskew_done;
    end

    initial begin
        logic [DW-1:0] d;
        reset = 1'b1;
        valid = 1'b0;
        lock  = 1'b0;
        tag   = NONE;
        step(1'b1, 1'b0, NONE);
        step(1'b1, 1'b1, ALL);
        check_idle("reset_state");
        reset = 1'b0;

        // Test 1: all lanes tag together
        step(1'b1, 1'b1, NONE);
        check("wait_first_write_enb", o_write_enb, 1'b1);
        push_exp(EV_SET, '0);
        push_exp(EV_DONE, '0);
        step(1'b1, 1'b1, ALL);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, NONE);
        check("t1_deskew_done", o_deskew_done, 1'b1);
        step(1'b0, 1'b0, NONE);
        check("hold_when_not_valid", {o_deskew_done, o_read_enb}, {1'b1, ALL});
        step(1'b1, 1'b0, NONE);
        check_idle("t5_lock_drop_deskewed");

        // Test 2: lane 0 at t0, middle lanes at t0+2, lane 19 at t0+5
        d = dvec(0, 5, 19, 0, 3);
        step(1'b1, 1'b1, NONE);
        push_exp(EV_SET, d);
        push_exp(EV_DONE, d);
        step(1'b1, 1'b1, L0);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, MID);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, L19);
        step(1'b1, 1'b1, NONE);
        check("t2_read_enb", o_read_enb, ALL);
        step(1'b1, 1'b0, NONE);
        check_idle("t2_back_to_idle");

        // Test 4: same round as test 2 with non-valid cycles carrying junk tags
        step(1'b1, 1'b1, NONE);
        push_exp(EV_SET, d);
        push_exp(EV_DONE, d);
        step(1'b1, 1'b1, L0);
        step(1'b0, 1'b1, ALL);
        step(1'b1, 1'b1, NONE);
        step(1'b0, 1'b1, ALL);
        step(1'b1, 1'b1, MID);
        step(1'b0, 1'b1, ALL);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, NONE);
        step(1'b0, 1'b1, ALL);
        step(1'b1, 1'b1, L19);
        step(1'b0, 1'b1, ALL);
        check("t4_set_held_no_valid", {o_set_fifo_delay, o_lane_delay}, {ALL, d});
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b0, NONE);
        check_idle("t4_back_to_idle");

        // Test 6: lane 3 tags twice; second tag ignored
        step(1'b1, 1'b1, NONE);
        d = dvec(3, 2, 3, 2, 0);
        push_exp(EV_SET, d);
        push_exp(EV_DONE, d);
        step(1'b1, 1'b1, L3);
        step(1'b1, 1'b1, L3);
        step(1'b1, 1'b1, NOT3);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b0, NONE);
        check_idle("t6_back_to_idle");

        // Test 3a: lane 7 arrives exactly at MAX_SKEW
        step(1'b1, 1'b1, NONE);
        d = dvec(7, 0, 7, 0, 16);
        push_exp(EV_SET, d);
        push_exp(EV_DONE, d);
        step(1'b1, 1'b1, NOT7);
        for (int i = 1; i <= 15; i++) step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, L7);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b0, NONE);
        check_idle("t3_back_to_idle");

        // Test 3b: lane 7 never arrives -> invalid skew, then recovery
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, NOT7);
        for (int i = 1; i <= 15; i++) step(1'b1, 1'b1, NONE);
        push_exp(EV_INV, '0);
        step(1'b1, 1'b1, NONE);
        check("t3_invalid_pulse", o_invalid_skew, 1'b1);
        step(1'b1, 1'b1, NONE);
        check("t3_pulse_one_cycle", {o_invalid_skew, o_write_enb}, {1'b0, 1'b1});
        d = dvec(0, 1, 0, 1, 0);
        push_exp(EV_SET, d);
        push_exp(EV_DONE, d);
        step(1'b1, 1'b1, L0);
        step(1'b1, 1'b1, NOT0);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b0, NONE);
        check_idle("t3_recovery_idle");

        // Test 5b: reset asserted mid-COUNT clears the round
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, L0);
        step(1'b1, 1'b1, NONE);
        reset = 1'b1;
        step(1'b1, 1'b1, MID);
        check_idle("t5_reset_mid_count");
        reset = 1'b0;
        step(1'b1, 1'b1, NONE);
        d = dvec(0, 0, 0, 0, 1);
        push_exp(EV_SET, d);
        push_exp(EV_DONE, d);
        step(1'b1, 1'b1, NOT0);
        step(1'b1, 1'b1, L0);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b1, NONE);
        step(1'b1, 1'b0, NONE);
        check_idle("t5_final_idle");

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: got %0d events outstanding, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
